// File: rtl/pulse_seq_pkg.sv
// Shared types and default sizing for the pulse burst sequencer.
package pulse_seq_pkg;

  localparam int TW_DEF   = 26;
  localparam int CNTW_DEF = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DELAY  = 3'd1,
    HIGH   = 3'd2,
    GAP    = 3'd3,
    FINISH = 3'd4
  } pulse_seq_state_e;

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter; zero flag marks the last cycle of the current phase.
module seq_timer #(
  parameter int TW = 26
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic          i_en,
  input  logic [TW-1:0] i_load_val,
  output logic          o_zero
);

  localparam logic [TW-1:0] TW_ONE = {{(TW-1){1'b0}}, 1'b1};

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - TW_ONE;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pulse_sequencer.sv
// Programmable burst controller: delay, then COUNT pulses of WIDTH high cycles
// separated by GAP low cycles. All outputs are registered.
module pulse_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int TW   = TW_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [TW-1:0]   delay_cfg,
  input  logic [TW-1:0]   width_cfg,
  input  logic [TW-1:0]   gap_cfg,
  input  logic [CNTW-1:0] count_cfg,
  output logic            pulse_out,
  output logic            busy,
  output logic            done,
  output logic [CNTW-1:0] pulses_done,
  output logic [2:0]      o_state_dbg
);

  localparam logic [TW-1:0]   TW_ONE  = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  // Timer reload value for a phase of v cycles; zero-length phases last one cycle.
  function automatic logic [TW-1:0] phase_m1(input logic [TW-1:0] v);
    return (v == '0) ? '0 : v - TW_ONE;
  endfunction

  pulse_seq_state_e r_state;
  logic [TW-1:0]    r_width_m1;
  logic [TW-1:0]    r_gap_m1;
  logic [CNTW-1:0]  r_count;
  logic             r_pulse;
  logic             r_busy;
  logic             r_done;
  logic [CNTW-1:0]  r_pulses_done;

  logic             w_accept;
  logic             w_last;
  logic             w_tmr_load;
  logic             w_tmr_en;
  logic [TW-1:0]    w_tmr_val;
  logic             w_tmr_zero;

  assign w_accept = start && !abort;
  assign w_last   = (r_pulses_done == (r_count - CNT_ONE));

  // The single timer is reloaded on every phase entry and counts down within it.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_en   = 1'b0;
    w_tmr_val  = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = (delay_cfg != '0) ? (delay_cfg - TW_ONE) : phase_m1(width_cfg);
        end
      end
      DELAY, GAP: begin
        if (w_tmr_zero) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = r_width_m1;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      HIGH: begin
        if (w_tmr_zero) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = r_gap_m1;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      default: begin
        w_tmr_load = 1'b0;
      end
    endcase
  end

  seq_timer #(
    .TW(TW)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_en       (w_tmr_en),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_width_m1    <= '0;
      r_gap_m1      <= '0;
      r_count       <= '0;
      r_pulse       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pulses_done <= '0;
    end else begin
      r_done <= 1'b0;
      if (abort && (r_state != IDLE)) begin
        // Abort drops the burst without a done strobe; the pulse count is kept.
        r_state <= IDLE;
        r_pulse <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_accept) begin
              r_width_m1    <= phase_m1(width_cfg);
              r_gap_m1      <= phase_m1(gap_cfg);
              r_count       <= count_cfg;
              r_pulses_done <= '0;
              if (count_cfg == '0) begin
                r_state <= FINISH;
                r_done  <= 1'b1;
              end else if (delay_cfg == '0) begin
                r_state <= HIGH;
                r_pulse <= 1'b1;
                r_busy  <= 1'b1;
              end else begin
                r_state <= DELAY;
                r_busy  <= 1'b1;
              end
            end
          end
          DELAY: begin
            if (w_tmr_zero) begin
              r_state <= HIGH;
              r_pulse <= 1'b1;
            end
          end
          HIGH: begin
            if (w_tmr_zero) begin
              r_pulse <= 1'b0;
              if (r_pulses_done != r_count) begin
                r_pulses_done <= r_pulses_done + CNT_ONE;
              end
              if (w_last) begin
                r_state <= FINISH;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state <= GAP;
              end
            end
          end
          GAP: begin
            if (w_tmr_zero) begin
              r_state <= HIGH;
              r_pulse <= 1'b1;
            end
          end
          FINISH: begin
            r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pulse_out   = r_pulse;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pulses_done = r_pulses_done;
  assign o_state_dbg = r_state;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Bench for pulse_sequencer: per-cycle expectations from a closed-form burst
// timeline are queued at start and popped each cycle.
module tb_pulse_sequencer;

  localparam int TW   = 26;
  localparam int CNTW = 16;
  localparam int EW   = CNTW + 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            abort;
  logic [TW-1:0]   delay_cfg;
  logic [TW-1:0]   width_cfg;
  logic [TW-1:0]   gap_cfg;
  logic [CNTW-1:0] count_cfg;
  logic            pulse_out;
  logic            busy;
  logic            done;
  logic [CNTW-1:0] pulses_done;
  logic [2:0]      state_dbg;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  logic [EW-1:0] exp_q[$];

  typedef struct {
    int d;
    int w;
    int g;
    int c;
    int exp_done_t;
    int exp_pulses;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  pulse_sequencer #(.TW(TW), .CNTW(CNTW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .delay_cfg   (delay_cfg),
    .width_cfg   (width_cfg),
    .gap_cfg     (gap_cfg),
    .count_cfg   (count_cfg),
    .pulse_out   (pulse_out),
    .busy        (busy),
    .done        (done),
    .pulses_done (pulses_done),
    .o_state_dbg (state_dbg)
  );

  // Expected {pulse_out, busy, done, pulses_done} in cycle t of a burst accepted at edge 0.
  function automatic logic [EW-1:0] model(input int t, input int d, input int w,
                                          input int g, input int c);
    int wp, gp, fin, rel, per, k, ph, pd;
    logic p, b, dn;
    wp = (w == 0) ? 1 : w;
    gp = (g == 0) ? 1 : g;
    if (c == 0) begin
      p = 1'b0; b = 1'b0; dn = (t == 1); pd = 0;
    end else begin
      fin = 1 + d + c * wp + (c - 1) * gp;
      if (t >= fin) begin
        p = 1'b0; b = 1'b0; dn = (t == fin); pd = c;
      end else begin
        b = 1'b1; dn = 1'b0;
        if (t <= d) begin
          p = 1'b0; pd = 0;
        end else begin
          rel = t - 1 - d;
          per = wp + gp;
          k   = rel / per;
          ph  = rel % per;
          p   = (ph < wp);
          pd  = k + ((ph >= wp) ? 1 : 0);
        end
      end
    end
    return {p, b, dn, pd[CNTW-1:0]};
  endfunction

  task automatic push_burst(input int d, input int w, input int g, input int c, input int n);
    for (int t = 1; t <= n; t++) exp_q.push_back(model(t, d, w, g, c));
  endtask

  task automatic push_idle(input int pd, input int n);
    for (int t = 0; t < n; t++) exp_q.push_back({3'b000, pd[CNTW-1:0]});
  endtask

  task automatic drive_start(input int d, input int w, input int g, input int c);
    delay_cfg = TW'(d);
    width_cfg = TW'(w);
    gap_cfg   = TW'(g);
    count_cfg = CNTW'(c);
    start     = 1'b1;
  endtask

  task automatic step(input string tag);
    logic [EW-1:0] act, exp_v;
    @(posedge clk);
    #1;
    cyc++;
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b0;
    act = {pulse_out, busy, done, pulses_done};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fails++;
      $display("FAIL %s queue_empty at t=%0d", tag, cyc);
    end else begin
      exp_v = exp_q.pop_front();
      if (act !== exp_v) begin
        n_fails++;
        $display("FAIL %s t=%0d got p=%0b b=%0b d=%0b pd=%0d expected p=%0b b=%0b d=%0b pd=%0d",
                 tag, cyc, act[EW-1], act[EW-2], act[EW-3], act[CNTW-1:0],
                 exp_v[EW-1], exp_v[EW-2], exp_v[EW-3], exp_v[CNTW-1:0]);
      end
    end
  endtask

  task automatic check_int(input string tag, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fails++;
      $display("FAIL %s got %0d expected %0d", tag, act, exp_v);
    end
  endtask

  initial begin
    int first_done;
    int len;

    vecs[0] = '{d: 3, w: 2, g: 4, c: 2, exp_done_t: 12, exp_pulses: 2};
    vecs[1] = '{d: 0, w: 0, g: 0, c: 3, exp_done_t: 6,  exp_pulses: 3};
    vecs[2] = '{d: 5, w: 3, g: 2, c: 0, exp_done_t: 1,  exp_pulses: 0};
    vecs[3] = '{d: 1, w: 3, g: 2, c: 2, exp_done_t: 10, exp_pulses: 2};
    vecs[4] = '{d: 2, w: 1, g: 0, c: 4, exp_done_t: 10, exp_pulses: 4};
    vecs[5] = '{d: 4, w: 6, g: 3, c: 3, exp_done_t: 29, exp_pulses: 3};

    // Clock/reset
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    delay_cfg = '0; width_cfg = '0; gap_cfg = '0; count_cfg = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_int("reset_outputs", int'({pulse_out, busy, done}), 0);
    check_int("reset_pulses_done", int'(pulses_done), 0);
    check_int("reset_state", int'(state_dbg), 0);

    // Table-driven bursts
    for (int i = 0; i < 6; i++) begin
      len = vecs[i].exp_done_t + 2;
      drive_start(vecs[i].d, vecs[i].w, vecs[i].g, vecs[i].c);
      push_burst(vecs[i].d, vecs[i].w, vecs[i].g, vecs[i].c, len);
      cyc = 0;
      first_done = 0;
      for (int t = 1; t <= len; t++) begin
        step($sformatf("vec%0d", i));
        if (done && first_done == 0) first_done = t;
      end
      check_int($sformatf("vec%0d_done_cycle", i), first_done, vecs[i].exp_done_t);
      check_int($sformatf("vec%0d_pulses", i), int'(pulses_done), vecs[i].exp_pulses);
    end

    // Restart mid-burst with new cfg, restart in FINISH, then start+abort in IDLE
    drive_start(3, 2, 4, 2);
    push_burst(3, 2, 4, 2, 12);
    cyc = 0;
    step("restart"); step("restart");
    delay_cfg = TW'(7); width_cfg = TW'(9); gap_cfg = TW'(1); count_cfg = CNTW'(5);
    start = 1'b1;
    repeat (10) step("restart");
    start = 1'b1;
    push_idle(2, 3);
    repeat (3) step("start_in_finish");
    start = 1'b1;
    abort = 1'b1;
    push_idle(2, 3);
    repeat (3) step("start_abort_idle");

    // Abort mid-pulse, then a fresh burst
    drive_start(3, 5, 1, 1);
    push_burst(3, 5, 1, 1, 6);
    cyc = 0;
    repeat (6) step("abort");
    abort = 1'b1;
    push_idle(0, 3);
    repeat (3) step("abort_after");
    drive_start(0, 1, 0, 1);
    push_burst(0, 1, 0, 1, 3);
    cyc = 0;
    repeat (3) step("post_abort");

    // Reset during GAP, then a clean burst
    drive_start(3, 2, 4, 2);
    push_burst(3, 2, 4, 2, 7);
    cyc = 0;
    repeat (7) step("gap_reset");
    reset = 1'b1;
    push_idle(0, 2);
    repeat (2) step("after_reset");
    check_int("after_reset_state", int'(state_dbg), 0);
    drive_start(1, 1, 1, 2);
    push_burst(1, 1, 1, 2, 8);
    cyc = 0;
    repeat (8) step("clean_burst");

    check_int("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
